// File: rtl/chunk_pkg.sv
// Shared line geometry, controller state encoding and line alignment helper
// for the chunk miss/refill sequencer.
package chunk_pkg;

    localparam int CHUNK_PART   = 128;
    localparam int ADDRESS_SIZE = 28;
    localparam int OFF          = $clog2(CHUNK_PART / 8);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EVICT_REQ = 3'd1,
        ST_FILL_REQ  = 3'd2,
        ST_FILL_WAIT = 3'd3,
        ST_LOAD      = 3'd4
    } ctrl_state_t;

    function automatic logic [ADDRESS_SIZE-1:0] line_align(input logic [ADDRESS_SIZE-1:0] addr);
        return {addr[ADDRESS_SIZE-1:OFF], {OFF{1'b0}}};
    endfunction

endpackage

// File: rtl/chunk_victim_select.sv
// Combinational victim pick: lowest-index invalid chunk, otherwise the oldest
// chunk (largest order_index, ties resolved toward the lowest index).
module chunk_victim_select
    import chunk_pkg::*;
#(
    parameter int CHUNK_COUNT = 4,
    parameter int ORDER_SIZE  = 16,
    parameter int IDX_W       = 2
) (
    input  logic [CHUNK_COUNT-1:0]            i_valid,
    input  logic [CHUNK_COUNT*ORDER_SIZE-1:0] i_order,
    output logic [IDX_W-1:0]                  o_victim
);

    logic                  w_found;
    logic [ORDER_SIZE-1:0] w_best;

    always_comb begin
        w_found  = 1'b0;
        w_best   = '0;
        o_victim = '0;
        for (int i = 0; i < CHUNK_COUNT; i++) begin
            if (!w_found && !i_valid[i]) begin
                o_victim = IDX_W'(i);
                w_found  = 1'b1;
            end
        end
        if (!w_found) begin
            w_best = i_order[ORDER_SIZE-1:0];
            for (int i = 1; i < CHUNK_COUNT; i++) begin
                if (i_order[i*ORDER_SIZE +: ORDER_SIZE] > w_best) begin
                    w_best   = i_order[i*ORDER_SIZE +: ORDER_SIZE];
                    o_victim = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/chunk_miss_controller.sv
// Miss/refill sequencer: IDLE -> [EVICT_REQ] -> FILL_REQ -> FILL_WAIT -> LOAD -> IDLE.
// Optional hit/miss/writeback counters under CHUNK_MISS_CONTROLLER_STATS_EN.
module chunk_miss_controller
    import chunk_pkg::*;
#(
    parameter int CHUNK_COUNT = 4,
    parameter int ORDER_SIZE  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ADDRESS_SIZE-1:0]           data_address,
    input  logic                              data_access,
    input  logic [ADDRESS_SIZE-1:0]           cmd_address,
    input  logic                              cmd_access,
    input  logic [CHUNK_COUNT-1:0]            chunk_contains,
    input  logic [CHUNK_COUNT-1:0]            chunk_contains_cmd,
    input  logic [CHUNK_COUNT-1:0]            chunk_dirty,
    input  logic [CHUNK_COUNT*ADDRESS_SIZE-1:0] chunk_save_address,
    input  logic [CHUNK_COUNT*CHUNK_PART-1:0] chunk_save_data,
    input  logic [CHUNK_COUNT*ORDER_SIZE-1:0] chunk_order_index,
    output logic                              busy,
    output logic [ADDRESS_SIZE-1:0]           new_address,
    output logic [CHUNK_PART-1:0]             new_data,
    output logic [CHUNK_COUNT-1:0]            new_data_save,
    output logic [ADDRESS_SIZE-1:0]           mem_address,
    output logic [CHUNK_PART-1:0]             mem_write_data,
    output logic                              mem_write_req,
    output logic                              mem_read_req,
    input  logic                              mem_ready,
    input  logic [CHUNK_PART-1:0]             mem_read_data,
    input  logic                              mem_read_valid
`ifdef CHUNK_MISS_CONTROLLER_STATS_EN
    ,
    output logic [31:0]                       stat_hits,
    output logic [31:0]                       stat_misses,
    output logic [31:0]                       stat_writebacks
`endif
);

    localparam int IDX_W = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
    localparam logic [CHUNK_COUNT-1:0] ONE_HOT_0 = {{(CHUNK_COUNT-1){1'b0}}, 1'b1};

    ctrl_state_t             r_state;
    logic [CHUNK_COUNT-1:0]  r_valid;
    logic [IDX_W-1:0]        r_victim;
    logic [ADDRESS_SIZE-1:0] r_miss_addr;
    logic [ADDRESS_SIZE-1:0] r_new_address;
    logic [CHUNK_PART-1:0]   r_new_data;
    logic [CHUNK_COUNT-1:0]  r_new_data_save;
    logic [ADDRESS_SIZE-1:0] r_mem_address;
    logic [CHUNK_PART-1:0]   r_mem_write_data;
    logic                    r_mem_write_req;
    logic                    r_mem_read_req;

    logic                    w_data_hit;
    logic                    w_cmd_hit;
    logic                    w_data_miss;
    logic                    w_cmd_miss;
    logic                    w_miss_start;
    logic [IDX_W-1:0]        w_victim;
    logic                    w_victim_dirty;
    logic [ADDRESS_SIZE-1:0] w_miss_line;
    logic [ADDRESS_SIZE-1:0] w_evict_addr;
    logic [CHUNK_PART-1:0]   w_evict_data;

    chunk_victim_select #(
        .CHUNK_COUNT (CHUNK_COUNT),
        .ORDER_SIZE  (ORDER_SIZE),
        .IDX_W       (IDX_W)
    ) u_victim_select (
        .i_valid  (r_valid),
        .i_order  (chunk_order_index),
        .o_victim (w_victim)
    );

    // Contents reported by a chunk are trusted only once this controller has filled it.
    assign w_data_hit     = data_access & (|(chunk_contains & r_valid));
    assign w_cmd_hit      = cmd_access & (|(chunk_contains_cmd & r_valid));
    assign w_data_miss    = data_access & ~w_data_hit;
    assign w_cmd_miss     = cmd_access & ~w_cmd_hit;
    assign w_miss_start   = (r_state == ST_IDLE) & (w_data_miss | w_cmd_miss);
    assign w_victim_dirty = r_valid[w_victim] & chunk_dirty[w_victim];
    assign w_miss_line    = w_data_miss ? line_align(data_address) : line_align(cmd_address);
    assign w_evict_addr   = line_align(chunk_save_address[w_victim*ADDRESS_SIZE +: ADDRESS_SIZE]);
    assign w_evict_data   = chunk_save_data[w_victim*CHUNK_PART +: CHUNK_PART];

    assign busy           = (r_state != ST_IDLE) | w_data_miss | w_cmd_miss;
    assign new_address    = r_new_address;
    assign new_data       = r_new_data;
    assign new_data_save  = r_new_data_save;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign mem_write_req  = r_mem_write_req;
    assign mem_read_req   = r_mem_read_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_valid          <= '0;
            r_victim         <= '0;
            r_miss_addr      <= '0;
            r_new_address    <= '0;
            r_new_data       <= '0;
            r_new_data_save  <= '0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_write_req  <= 1'b0;
            r_mem_read_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss_start) begin
                        r_miss_addr <= w_miss_line;
                        r_victim    <= w_victim;
                        if (w_victim_dirty) begin
                            r_mem_write_req  <= 1'b1;
                            r_mem_address    <= w_evict_addr;
                            r_mem_write_data <= w_evict_data;
                            r_state          <= ST_EVICT_REQ;
                        end else begin
                            r_mem_read_req <= 1'b1;
                            r_mem_address  <= w_miss_line;
                            r_state        <= ST_FILL_REQ;
                        end
                    end
                end
                ST_EVICT_REQ: begin
                    if (mem_ready) begin
                        r_mem_write_req <= 1'b0;
                        r_mem_read_req  <= 1'b1;
                        r_mem_address   <= r_miss_addr;
                        r_state         <= ST_FILL_REQ;
                    end
                end
                ST_FILL_REQ: begin
                    if (mem_ready) begin
                        r_mem_read_req <= 1'b0;
                        r_state        <= ST_FILL_WAIT;
                    end
                end
                ST_FILL_WAIT: begin
                    if (mem_read_valid) begin
                        r_new_data      <= mem_read_data;
                        r_new_address   <= r_miss_addr;
                        r_new_data_save <= ONE_HOT_0 << r_victim;
                        r_state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_new_data_save   <= '0;
                    r_valid[r_victim] <= 1'b1;
                    r_state           <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CHUNK_MISS_CONTROLLER_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;
    logic [31:0] r_stat_writebacks;
    logic        w_hit_cycle;

    assign w_hit_cycle = (r_state == ST_IDLE) & ~(w_data_miss | w_cmd_miss) & (data_access | cmd_access);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_hits       <= '0;
            r_stat_misses     <= '0;
            r_stat_writebacks <= '0;
        end else begin
            if (w_hit_cycle && (r_stat_hits != '1))
                r_stat_hits <= r_stat_hits + 32'd1;
            if (w_miss_start && (r_stat_misses != '1))
                r_stat_misses <= r_stat_misses + 32'd1;
            if (w_miss_start && w_victim_dirty && (r_stat_writebacks != '1))
                r_stat_writebacks <= r_stat_writebacks + 32'd1;
        end
    end

    assign stat_hits       = r_stat_hits;
    assign stat_misses     = r_stat_misses;
    assign stat_writebacks = r_stat_writebacks;
`endif

endmodule

// File: tb/tb_chunk_miss_controller.sv
// Directed bench for chunk_miss_controller with a chunk-storage/memory model and
// scoreboards for memory requests and chunk loads.
module tb_chunk_miss_controller;
    import chunk_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [27:0]           data_address;
    logic                  data_access;
    logic [27:0]           cmd_address;
    logic                  cmd_access;
    logic [3:0]            chunk_contains;
    logic [3:0]            chunk_contains_cmd;
    logic [3:0]            chunk_dirty;
    logic [111:0]          chunk_save_address;
    logic [511:0]          chunk_save_data;
    logic [63:0]           chunk_order_index;
    logic                  busy;
    logic [27:0]           new_address;
    logic [127:0]          new_data;
    logic [3:0]            new_data_save;
    logic [27:0]           mem_address;
    logic [127:0]          mem_write_data;
    logic                  mem_write_req;
    logic                  mem_read_req;
    logic                  mem_ready;
    logic [127:0]          mem_read_data;
    logic                  mem_read_valid;
`ifdef CHUNK_MISS_CONTROLLER_STATS_EN
    logic [31:0]           stat_hits;
    logic [31:0]           stat_misses;
    logic [31:0]           stat_writebacks;
`endif

    chunk_miss_controller dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_address       (data_address),
        .data_access        (data_access),
        .cmd_address        (cmd_address),
        .cmd_access         (cmd_access),
        .chunk_contains     (chunk_contains),
        .chunk_contains_cmd (chunk_contains_cmd),
        .chunk_dirty        (chunk_dirty),
        .chunk_save_address (chunk_save_address),
        .chunk_save_data    (chunk_save_data),
        .chunk_order_index  (chunk_order_index),
        .busy               (busy),
        .new_address        (new_address),
        .new_data           (new_data),
        .new_data_save      (new_data_save),
        .mem_address        (mem_address),
        .mem_write_data     (mem_write_data),
        .mem_write_req      (mem_write_req),
        .mem_read_req       (mem_read_req),
        .mem_ready          (mem_ready),
        .mem_read_data      (mem_read_data),
        .mem_read_valid     (mem_read_valid)
`ifdef CHUNK_MISS_CONTROLLER_STATS_EN
        ,
        .stat_hits          (stat_hits),
        .stat_misses        (stat_misses),
        .stat_writebacks    (stat_writebacks)
`endif
    );

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_exp_t;

    typedef struct {
        logic [3:0]   oh;
        logic [27:0]  addr;
        logic [127:0] data;
    } load_exp_t;

    mem_exp_t  mem_q[$];
    load_exp_t load_q[$];

    int n_total = 0;
    int n_bad   = 0;

    // chunk storage model
    logic [27:0]  line_m[4];
    logic [3:0]   loaded_m;
    logic [15:0]  order_m[4];
    logic [27:0]  save_addr_m[4];
    logic [127:0] save_data_m[4];

    logic         resp_en;
    logic         stray_valid;
    logic         ld_pend;
    int           ld_idx;
    logic [27:0]  ld_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] lalign(input logic [27:0] a);
        return {a[27:4], 4'h0};
    endfunction

    function automatic logic [127:0] fill_data(input logic [27:0] a);
        if (a == 28'h0A50000)
            return {32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h87654321};
        return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
    endfunction

    always_comb begin
        chunk_contains     = '0;
        chunk_contains_cmd = '0;
        chunk_order_index  = '0;
        chunk_save_address = '0;
        chunk_save_data    = '0;
        for (int i = 0; i < 4; i++) begin
            chunk_contains[i]               = loaded_m[i] && (line_m[i] == lalign(data_address));
            chunk_contains_cmd[i]           = loaded_m[i] && (line_m[i] == lalign(cmd_address));
            chunk_order_index[i*16 +: 16]   = order_m[i];
            chunk_save_address[i*28 +: 28]  = save_addr_m[i];
            chunk_save_data[i*128 +: 128]   = save_data_m[i];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // memory responder: one-cycle read response after an accepted fill request
    initial begin
        logic        pend;
        logic [27:0] paddr;
        mem_read_valid = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clk);
            pend  = mem_read_req && mem_ready;
            paddr = mem_address;
            @(posedge clk);
            #1;
            mem_read_valid = (pend && resp_en) || stray_valid;
            mem_read_data  = fill_data(paddr);
        end
    end

    // scoreboard monitor for memory requests and chunk loads; applies loads to the model
    initial begin
        mem_exp_t  me;
        load_exp_t le;
        ld_pend = 1'b0;
        ld_idx  = 0;
        ld_addr = '0;
        forever begin
            @(negedge clk);
            if ((mem_write_req || mem_read_req) && mem_ready) begin
                if (mem_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $error("FAIL mem_unexpected: observed addr=%0h expected no request", mem_address);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_is_write", 128'(mem_write_req), 128'(me.wr));
                    check("mem_addr", 128'(mem_address), 128'(me.addr));
                    if (me.wr) check("mem_wdata", mem_write_data, me.data);
                end
            end
            ld_pend = 1'b0;
            if (new_data_save != 4'b0) begin
                if (load_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $error("FAIL load_unexpected: observed strobe=%b expected none", new_data_save);
                end else begin
                    le = load_q.pop_front();
                    check("load_strobe", 128'(new_data_save), 128'(le.oh));
                    check("load_addr", 128'(new_address), 128'(le.addr));
                    check("load_data", new_data, le.data);
                end
                for (int i = 0; i < 4; i++) if (new_data_save[i]) ld_idx = i;
                ld_addr = new_address;
                ld_pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ld_pend) begin
                line_m[ld_idx]   = ld_addr;
                loaded_m[ld_idx] = 1'b1;
                for (int j = 0; j < 4; j++) if (j != ld_idx) order_m[j] = order_m[j] + 16'd1;
                order_m[ld_idx] = 16'd0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output int ncyc);
        ncyc = 0;
        @(negedge clk);
        while (busy === 1'b1 && ncyc < budget) begin
            ncyc++;
            @(negedge clk);
        end
        if (busy !== 1'b0) begin
            n_total++;
            n_bad++;
            $error("FAIL busy_timeout: observed busy=%b after %0d cycles expected 0", busy, ncyc);
        end
    endtask

    task automatic push_fill(input logic [27:0] a, input logic [3:0] oh);
        mem_exp_t  me;
        load_exp_t le;
        me.wr = 1'b0; me.addr = lalign(a); me.data = '0;
        mem_q.push_back(me);
        le.oh = oh; le.addr = lalign(a); le.data = fill_data(lalign(a));
        load_q.push_back(le);
    endtask

    task automatic data_miss(input string tag, input logic [27:0] a, input logic [3:0] oh,
                             input logic ev, input logic [27:0] ev_a, input logic [127:0] ev_d);
        mem_exp_t me;
        int       n;
        if (ev) begin
            me.wr = 1'b1; me.addr = ev_a; me.data = ev_d;
            mem_q.push_back(me);
        end
        push_fill(a, oh);
        data_address = a;
        data_access  = 1'b1;
        wait_idle(20, n);
        check({tag, "_busy_cycles"}, 128'(n), ev ? 128'd5 : 128'd4);
        tick();
        data_access = 1'b0;
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        data_address = '0;
        data_access  = 1'b0;
        cmd_address  = '0;
        cmd_access   = 1'b0;
        chunk_dirty  = '0;
        mem_ready    = 1'b1;
        resp_en      = 1'b1;
        stray_valid  = 1'b0;
        loaded_m     = '0;
        for (int i = 0; i < 4; i++) begin
            line_m[i] = '0; order_m[i] = '0; save_addr_m[i] = '0; save_data_m[i] = '0;
        end

        // reset state
        tick(); tick();
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_rreq", 128'(mem_read_req), 128'd0);
        check("rst_wreq", 128'(mem_write_req), 128'd0);
        check("rst_strobe", 128'(new_data_save), 128'd0);
        check("rst_mem_addr", 128'(mem_address), 128'd0);
        check("rst_new_addr", 128'(new_address), 128'd0);
        check("rst_new_data", new_data, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // cold miss
        data_miss("cold", 28'h0A5000F, 4'b0001, 1'b0, '0, '0);

        // fill remaining chunks, then dirty eviction of the oldest chunk
        data_miss("fill1", 28'h0C10000, 4'b0010, 1'b0, '0, '0);
        data_miss("fill2", 28'h0C20000, 4'b0100, 1'b0, '0, '0);
        data_miss("fill3", 28'h0C30000, 4'b1000, 1'b0, '0, '0);
        order_m[0] = 16'd0; order_m[1] = 16'd1; order_m[2] = 16'd2; order_m[3] = 16'd3;
        save_addr_m[3] = 28'h0C30000;
        save_data_m[3] = {64'h5555AAAA5555AAAA, 64'h0123456789ABCDEF};
        chunk_dirty    = 4'b1000;
        data_miss("dirty", 28'h0B00000, 4'b1000, 1'b1, 28'h0C30000,
                  {64'h5555AAAA5555AAAA, 64'h0123456789ABCDEF});
        chunk_dirty = '0;

        // simultaneous data and cmd misses
        tick();
        push_fill(28'h0100000, 4'b0100);
        push_fill(28'h0200000, 4'b0010);
        data_address = 28'h0100000;
        cmd_address  = 28'h0200000;
        data_access  = 1'b1;
        cmd_access   = 1'b1;
        wait_idle(40, n);
        check("dual_busy_cycles", 128'(n), 128'd8);
        tick();
        data_access = 1'b0;
        cmd_access  = 1'b0;

        // memory back-pressure in FILL_REQ
        tick();
        mem_ready = 1'b0;
        push_fill(28'h0300000, 4'b0001);
        data_address = 28'h0300000;
        data_access  = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_rreq", 128'(mem_read_req), 128'd1);
            check("stall_addr", 128'(mem_address), 128'h0300000);
            check("stall_strobe", 128'(new_data_save), 128'd0);
        end
        tick();
        mem_ready = 1'b1;
        wait_idle(20, n);
        tick();
        data_access = 1'b0;

        // reset while waiting for fill data, then a stray response
        tick();
        resp_en = 1'b0;
        begin
            mem_exp_t me;
            me.wr = 1'b0; me.addr = 28'h0400000; me.data = '0;
            mem_q.push_back(me);
        end
        data_address = 28'h0400000;
        data_access  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("fw_rreq", 128'(mem_read_req), 128'd0);
        check("fw_busy", 128'(busy), 128'd1);
        tick();
        rst_n       = 1'b0;
        data_access = 1'b0;
        stray_valid = 1'b1;
        @(negedge clk);
        check("rstmid_strobe", 128'(new_data_save), 128'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_busy", 128'(busy), 128'd0);
        check("rstmid_mem_addr", 128'(mem_address), 128'd0);
        tick();
        @(negedge clk);
        check("stray_strobe", 128'(new_data_save), 128'd0);
        tick();
        stray_valid = 1'b0;
        resp_en     = 1'b1;
        tick();
        // chunk2 still reports 0x0100000, but valid was cleared: must miss into chunk0
        push_fill(28'h0100000, 4'b0001);
        data_address = 28'h0100000;
        data_access  = 1'b1;
        @(negedge clk);
        check("valid_cleared_miss", 128'(busy), 128'd1);
        wait_idle(20, n);
        tick();
        data_access = 1'b0;

`ifdef CHUNK_MISS_CONTROLLER_STATS_EN
        tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("stat_hits_rst", 128'(stat_hits), 128'd0);
        tick();
        push_fill(28'h0200000, 4'b0001);
        data_address = 28'h0200000;
        data_access  = 1'b1;
        wait_idle(20, n);
        tick(); tick(); tick();
        data_access = 1'b0;
        @(negedge clk);
        check("stat_misses", 128'(stat_misses), 128'd1);
        check("stat_hits", 128'(stat_hits), 128'd3);
        check("stat_writebacks", 128'(stat_writebacks), 128'd0);
`endif

        tick(); tick();
        check("mem_q_drained", 128'(mem_q.size()), 128'd0);
        check("load_q_drained", 128'(load_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
